ring_buffer_ctrl: RTL



---
 rtl/ring_buffer_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ring_buffer_ctrl.sv
// ring_buffer_ctrl: sequences one unreset ring buffer (8-bit data, one-cycle
// `available` pulse on pop). Round-robin arbitration between producers A and B
// on the write side, a valid/ready consumer on the read side, and a post-reset
// flush that discards whatever the buffer still holds.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// FLUSH_REQ | post-reset pop issued to discard a stale byte
// FLUSH_CHK | look at `available`; a byte came back -> pop again, else done
// IDLE      | waiting for a buffered byte and a free consumer slot
// REQ       | pop issued this cycle; count drops at the edge leaving REQ
// WAIT      | pop result arrives; latch it or flag underflow
// HOLD      | byte presented to the consumer until c_valid & c_ready

module ring_buffer_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [7:0]        b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [7:0]        buf_in,
    output logic              buf_wen,
    output logic              buf_ren,
    input  logic [7:0]        buf_out,
    input  logic              buf_available,
    output logic [7:0]        c_data,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              flushing,
    output logic              underflow_err
);

    // A full buffer has equal cursors and reads as empty, so one slot stays unused.
    localparam logic [ADDR_W-1:0] CAP = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_FLUSH_REQ,
        ST_FLUSH_CHK,
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e            state_q;
    logic              ren_q;
    logic [7:0]        c_data_q;
    logic              c_valid_q;
    logic              underflow_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;
    logic              prefer_b_q;
    logic              prefer_b_d;

    logic              arb_en;
    logic              grant_a;
    logic              grant_b;
    logic              pop_commit;

    assign flushing = (state_q == ST_FLUSH_REQ) || (state_q == ST_FLUSH_CHK);
    assign full     = (count_q == CAP);
    assign arb_en   = !flushing && !full;

    assign grant_a  = arb_en && a_valid && (!b_valid || !prefer_b_q);
    assign grant_b  = arb_en && b_valid && (!a_valid || prefer_b_q);

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign buf_wen  = grant_a || grant_b;
    assign buf_in   = grant_a ? a_data : (grant_b ? b_data : 8'h00);

    // The first cycle out of reset is already a flush pop, so the pop register
    // resets high; gating with rst_n keeps the unreset buffer untouched while
    // reset is held.
    assign buf_ren       = ren_q && rst_n;

    assign pop_commit    = (state_q == ST_REQ);
    assign c_data        = c_data_q;
    assign c_valid       = c_valid_q;
    assign count         = count_q;
    assign underflow_err = underflow_q;

    // Next occupancy: a write and a committed pop on the same edge cancel.
    always_comb begin
        count_d = count_q;
        if (buf_wen && !pop_commit) begin
            count_d = count_q + ADDR_W'(1);
        end else if (!buf_wen && pop_commit) begin
            count_d = count_q - ADDR_W'(1);
        end
    end

    // Round-robin pointer moves only when a transfer is actually granted.
    always_comb begin
        prefer_b_d = prefer_b_q;
        if (grant_a) begin
            prefer_b_d = 1'b1;
        end else if (grant_b) begin
            prefer_b_d = 1'b0;
        end
    end

    // Occupancy counter and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            prefer_b_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            prefer_b_q <= prefer_b_d;
        end
    end

    // Flush and read sequencing with registered pop strobe and consumer outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FLUSH_REQ;
            ren_q       <= 1'b1;
            c_data_q    <= 8'h00;
            c_valid_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FLUSH_REQ: begin
                    ren_q   <= 1'b0;
                    state_q <= ST_FLUSH_CHK;
                end
                ST_FLUSH_CHK: begin
                    if (buf_available) begin
                        ren_q   <= 1'b1;
                        state_q <= ST_FLUSH_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if ((count_q != '0) && !c_valid_q) begin
                        ren_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    ren_q   <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (buf_available) begin
                        c_data_q  <= buf_out;
                        c_valid_q <= 1'b1;
                        state_q   <= ST_HOLD;
                    end else begin
                        underflow_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (c_valid_q && c_ready) begin
                        c_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    ren_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
